fir_coeff_loader: RTL and testbench

FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

---
 rtl/fir_pkg.sv | 17 +
 rtl/fir_coeff_loader.sv | 119 +++++++++++
 tb/tb_fir_coeff_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient loader and the decimator it feeds:
// loader FSM state encoding and default parameter values.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_ERR    = 2'd3
  } fir_state_e;

  localparam int ORD_DEF        = 255;
  localparam int COEFF_SIZE_DEF = 16;
  localparam int TIMEOUT_DEF    = 1024;
  localparam int SETTLE_DEF     = 4;

endpackage

// File: rtl/fir_coeff_loader.sv
// Streams ORD+1 coefficients into the decimator coefficient RAM, one write per
// accepted word, with stall timeout, abort and a post-load settle window.
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int ORD        = ORD_DEF,
  parameter int COEFF_SIZE = COEFF_SIZE_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int SETTLE     = SETTLE_DEF,
  localparam int AW        = $clog2(ORD + 1),
  localparam int SCW       = $clog2(TIMEOUT),
  localparam int STW       = $clog2(SETTLE + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         s_valid,
  input  logic signed [COEFF_SIZE-1:0] s_data,
  output logic                         s_ready,
  output logic                         c_we,
  output logic signed [COEFF_SIZE-1:0] c_in,
  output logic [AW-1:0]                c_addr,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  fir_state_e     state_q, state_d;
  logic [AW-1:0]  wcnt_q, wcnt_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic [STW-1:0] stcnt_q, stcnt_d;
  logic           done_d, err_d, busy_d;
  logic           hs;

  // abort blocks acceptance in the same cycle, so a colliding word is never written
  assign s_ready = (state_q == ST_LOAD) && !abort;
  assign hs      = s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    stcnt_d = stcnt_q;
    done_d  = 1'b0;
    err_d   = err;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          wcnt_d  = '0;
          scnt_d  = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else if (s_valid) begin
          scnt_d = '0;
          if (wcnt_q == AW'(ORD)) begin
            state_d = ST_SETTLE;
            stcnt_d = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end else if (scnt_q == SCW'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        // counts the final-write cycle plus SETTLE more before reporting done
        if (stcnt_q == STW'(SETTLE)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          stcnt_d = stcnt_q + 1'b1;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_LOAD) || (state_d == ST_SETTLE);
  end

  // Registered state, counters and write port (one-cycle write latency)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      stcnt_q <= '0;
      c_we    <= 1'b0;
      c_in    <= '0;
      c_addr  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      stcnt_q <= stcnt_d;
      c_we    <= hs;
      if (hs) begin
        c_in   <= s_data;
        c_addr <= wcnt_q;
      end
      busy <= busy_d;
      done <= done_d;
      err  <= err_d;
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized scenario bench for fir_coeff_loader (ORD=7, TIMEOUT=8, SETTLE=4)
// with a transaction-level model of expected writes and done timing.
module tb_fir_coeff_loader;

  localparam int ORD     = 7;
  localparam int CW      = 16;
  localparam int TIMEOUT = 8;
  localparam int SETTLE  = 4;
  localparam int AW      = $clog2(ORD + 1);

  logic                 clk = 1'b0;
  logic                 rst, start, abort, s_valid;
  logic signed [CW-1:0] s_data;
  logic                 s_ready, c_we, busy, done, err;
  logic signed [CW-1:0] c_in;
  logic [AW-1:0]        c_addr;

  fir_coeff_loader #(.ORD(ORD), .COEFF_SIZE(CW), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .c_we(c_we), .c_in(c_in), .c_addr(c_addr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int c; int a; int d; } wr_t;
  wr_t wq[$];
  wr_t eq[$];
  int  done_q[$];
  int  cyc = 0;
  int  exp_idx = 0;
  int  checks = 0;
  int  failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (c_we === 1'b1) wq.push_back('{cyc, int'(c_addr), int'(c_in)});
    if (done === 1'b1) done_q.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wq.delete();
    eq.delete();
    done_q.delete();
  endtask

  task automatic begin_session(input logic with_abort);
    start = 1'b1;
    abort = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
    exp_idx = 0;
  endtask

  // A word presented on drive cycle N is written during cycle N+1 if accepted.
  task automatic send(input logic signed [CW-1:0] d, input int gap, input logic ab,
                      input logic st, input logic acc);
    s_valid = 1'b0;
    repeat (gap) tick();
    s_valid = 1'b1;
    s_data  = d;
    abort   = ab;
    start   = st;
    if (acc) begin
      eq.push_back('{cyc + 1, exp_idx, int'(d)});
      exp_idx++;
    end
    tick();
    s_valid = 1'b0;
    abort   = 1'b0;
    start   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b0; s_valid = 1'b1; s_data = 16'sh1234;
    tick();
    tick();
    rst = 1'b0; start = 1'b0; s_valid = 1'b0;
    checks++; if (c_we !== 1'b0)  begin failures++; $display("FAIL reset_c_we got %b want 0", c_we); end
    checks++; if (c_in !== '0)    begin failures++; $display("FAIL reset_c_in got %h want 0", c_in); end
    checks++; if (c_addr !== '0)  begin failures++; $display("FAIL reset_c_addr got %0d want 0", c_addr); end
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)  begin failures++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0)   begin failures++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
    tick();
    clear_logs();
  endtask

  task automatic test_back_to_back();
    clear_logs();
    begin_session(1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got %b want 1", busy); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got %b want 1", s_ready); end
    for (int i = 0; i <= ORD; i++) send(CW'(i + 1), 0, 1'b0, 1'b0, 1'b1);
    // abort, start and data during settle must all be ignored
    s_valid = 1'b1; abort = 1'b1; start = 1'b1; s_data = 16'sh5555;
    #1;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL b2b_settle_ready got %b want 0", s_ready); end
    tick();
    tick();
    s_valid = 1'b0; abort = 1'b0; start = 1'b0;
    repeat (SETTLE + 4) tick();
    checks++; if (wq.size() != eq.size()) begin failures++; $display("FAIL b2b_count got %0d want %0d", wq.size(), eq.size()); end
    for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
      checks++;
      if (wq[i].c != eq[i].c || wq[i].a != eq[i].a || wq[i].d != eq[i].d) begin
        failures++;
        $display("FAIL b2b_write%0d got cyc=%0d a=%0d d=%0d want cyc=%0d a=%0d d=%0d", i,
                 wq[i].c, wq[i].a, wq[i].d, eq[i].c, eq[i].a, eq[i].d);
      end
    end
    checks++; if (done_q.size() != 1) begin failures++; $display("FAIL b2b_done_count got %0d want 1", done_q.size()); end
    else begin
      checks++; if (done_q[0] != eq[$].c + SETTLE + 1) begin failures++; $display("FAIL b2b_done_cyc got %0d want %0d", done_q[0], eq[$].c + SETTLE + 1); end
    end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL b2b_err got %b want 0", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got %b want 0", busy); end
  endtask

  task automatic test_gapped();
    int g;
    clear_logs();
    begin_session(1'b0);
    for (int i = 0; i <= ORD; i++) begin
      g = (i == 4) ? TIMEOUT - 1 : int'($urandom_range(1, 3));
      send(CW'($urandom), g, 1'b0, 1'b0, 1'b1);
    end
    repeat (SETTLE + 3) tick();
    checks++; if (wq.size() != eq.size()) begin failures++; $display("FAIL gap_count got %0d want %0d", wq.size(), eq.size()); end
    for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
      checks++;
      if (wq[i].c != eq[i].c || wq[i].a != eq[i].a || wq[i].d != eq[i].d) begin
        failures++;
        $display("FAIL gap_write%0d got cyc=%0d a=%0d d=%0d want cyc=%0d a=%0d d=%0d", i,
                 wq[i].c, wq[i].a, wq[i].d, eq[i].c, eq[i].a, eq[i].d);
      end
    end
    checks++; if (done_q.size() != 1) begin failures++; $display("FAIL gap_done_count got %0d want 1", done_q.size()); end
    else begin
      checks++; if (done_q[0] != eq[$].c + SETTLE + 1) begin failures++; $display("FAIL gap_done_cyc got %0d want %0d", done_q[0], eq[$].c + SETTLE + 1); end
    end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL gap_err got %b want 0", err); end
  endtask

  task automatic test_timeout();
    clear_logs();
    begin_session(1'b0);
    send(CW'($urandom), 0, 1'b0, 1'b0, 1'b1);
    send(CW'($urandom), 1, 1'b0, 1'b0, 1'b1);
    // TIMEOUT stall cycles after the last handshake trip the error
    repeat (TIMEOUT - 1) tick();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL to_err_early got %b want 0", err); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL to_busy_early got %b want 1", busy); end
    tick();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err got %b want 1", err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL to_busy got %b want 0", busy); end
    repeat (4) tick();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err_sticky got %b want 1", err); end
    checks++; if (wq.size() != 2) begin failures++; $display("FAIL to_count got %0d want 2", wq.size()); end
    checks++; if (done_q.size() != 0) begin failures++; $display("FAIL to_done got %0d want 0", done_q.size()); end
  endtask

  task automatic test_abort_collision();
    clear_logs();
    begin_session(1'b0);
    for (int i = 0; i < 3; i++) send(CW'($urandom), 0, 1'b0, 1'b0, 1'b1);
    send(CW'($urandom), 0, 1'b1, 1'b0, 1'b0);
    checks++; if (c_we !== 1'b0) begin failures++; $display("FAIL ab_c_we got %b want 0", c_we); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ab_err got %b want 1", err); end
    repeat (3) tick();
    checks++; if (wq.size() != 3) begin failures++; $display("FAIL ab_count got %0d want 3", wq.size()); end
    for (int i = 0; i < 3 && i < wq.size(); i++) begin
      checks++;
      if (wq[i].a != i || wq[i].d != eq[i].d) begin
        failures++; $display("FAIL ab_write%0d got a=%0d d=%0d want a=%0d d=%0d", i, wq[i].a, wq[i].d, i, eq[i].d);
      end
    end
    clear_logs();
    begin_session(1'b1);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ab_restart_err got %b want 0", err); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ab_restart_busy got %b want 1", busy); end
    for (int i = 0; i <= ORD; i++) send(CW'($urandom), int'($urandom_range(0, 2)), 1'b0, 1'b0, 1'b1);
    repeat (SETTLE + 3) tick();
    checks++; if (wq.size() != eq.size()) begin failures++; $display("FAIL ab_full_count got %0d want %0d", wq.size(), eq.size()); end
    for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
      checks++;
      if (wq[i].c != eq[i].c || wq[i].a != eq[i].a || wq[i].d != eq[i].d) begin
        failures++;
        $display("FAIL ab_full_write%0d got cyc=%0d a=%0d d=%0d want cyc=%0d a=%0d d=%0d", i,
                 wq[i].c, wq[i].a, wq[i].d, eq[i].c, eq[i].a, eq[i].d);
      end
    end
    checks++; if (done_q.size() != 1) begin failures++; $display("FAIL ab_full_done got %0d want 1", done_q.size()); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ab_full_err got %b want 0", err); end
  endtask

  task automatic test_mid_reset();
    clear_logs();
    begin_session(1'b0);
    for (int i = 0; i < 5; i++) send(CW'($urandom), 0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1; s_valid = 1'b1; s_data = CW'($urandom); start = 1'b1;
    tick();
    rst = 1'b0; s_valid = 1'b0; start = 1'b0;
    checks++; if (c_we !== 1'b0) begin failures++; $display("FAIL mr_c_we got %b want 0", c_we); end
    checks++; if (c_in !== '0) begin failures++; $display("FAIL mr_c_in got %h want 0", c_in); end
    checks++; if (c_addr !== '0) begin failures++; $display("FAIL mr_c_addr got %0d want 0", c_addr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mr_busy got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL mr_err got %b want 0", err); end
    repeat (SETTLE + 6) tick();
    checks++; if (wq.size() != 5) begin failures++; $display("FAIL mr_count got %0d want 5", wq.size()); end
    checks++; if (done_q.size() != 0) begin failures++; $display("FAIL mr_done got %0d want 0", done_q.size()); end
    // start pulses during the next session must not restart it
    clear_logs();
    begin_session(1'b0);
    for (int i = 0; i <= ORD; i++) send(CW'($urandom), 0, 1'b0, (i == 3 || i == 5), 1'b1);
    repeat (SETTLE + 3) tick();
    checks++; if (wq.size() != eq.size()) begin failures++; $display("FAIL mr_next_count got %0d want %0d", wq.size(), eq.size()); end
    for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
      checks++;
      if (wq[i].c != eq[i].c || wq[i].a != eq[i].a || wq[i].d != eq[i].d) begin
        failures++;
        $display("FAIL mr_next_write%0d got cyc=%0d a=%0d d=%0d want cyc=%0d a=%0d d=%0d", i,
                 wq[i].c, wq[i].a, wq[i].d, eq[i].c, eq[i].a, eq[i].d);
      end
    end
    checks++; if (done_q.size() != 1) begin failures++; $display("FAIL mr_next_done got %0d want 1", done_q.size()); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_timeout();
    test_abort_collision();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
